// File: rtl/ram_dp_128kx8.sv
// Simple dual-port 128K x 8 RAM (one write port, one registered read port) for the scan-converter buffer.
// Optional macro RAM_DP_CLEAR_ON_RESET_EN zero-fills the array after reset and reports progress on busy.
module ram_dp_128kx8 #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ai,
  input  logic [DATA_W-1:0] i,
  input  logic              w,
  input  logic [ADDR_W-1:0] ao,
  input  logic              r,
  output logic [DATA_W-1:0] o,
  output logic              busy
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] o_q;
  logic              busy_int;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

`ifdef RAM_DP_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;

  // busy is already high while reset is held, so the first edge after release clears address 0.
  always_comb begin
    busy_d     = busy_q;
    clr_addr_d = clr_addr_q;
    if (busy_q) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == {ADDR_W{1'b1}}) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= 1'b1;
      clr_addr_q <= '0;
    end else begin
      busy_q     <= busy_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign busy_int = busy_q;
  assign we       = busy_q | w;
  assign wa       = busy_q ? clr_addr_q : ai;
  assign wd       = busy_q ? {DATA_W{1'b0}} : i;
`else
  assign busy_int = 1'b0;
  assign we       = w;
  assign wa       = ai;
  assign wd       = i;
`endif

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // Read-first on collisions: this samples mem before the same-edge write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_q <= '0;
    end else if (busy_int) begin
      o_q <= '0;
    end else if (r) begin
      o_q <= mem[ao];
    end
  end

  assign o    = o_q;
  assign busy = busy_int;

endmodule

// File: tb/tb_ram_dp_128kx8.sv
// Scoreboard bench for ram_dp_128kx8: stimulus pushes expected read data, a monitor pops and compares.
// Define RAM_DP_CLEAR_ON_RESET_EN to also exercise the clear-on-reset sequence.
module tb_ram_dp_128kx8;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] ai, ao;
  logic [7:0]  i;
  logic        w, r;
  logic [7:0]  o;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mdl [int];
  logic [7:0] exp_q [$];
  logic [7:0] exp_o = 8'h00;
  logic [16:0] pool [16];

  ram_dp_128kx8 dut (
    .clk(clk), .reset(reset), .ai(ai), .i(i), .w(w),
    .ao(ao), .r(r), .o(o), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [16:0] a);
    if (mdl.exists(int'(a))) return mdl[int'(a)];
    return 8'h00;
  endfunction

  task automatic cyc(input logic wv, input logic [16:0] wa, input logic [7:0] wdat,
                     input logic rv, input logic [16:0] ra);
    @(negedge clk);
    w = wv; ai = wa; i = wdat; r = rv; ao = ra;
    if (rv) exp_q.push_back(model_rd(ra));
    if (wv) mdl[int'(wa)] = wdat;
  endtask

  task automatic release_reset(output int busy_cycles);
    busy_cycles = 0;
    @(negedge clk);
    reset = 1'b0;
`ifdef RAM_DP_CLEAR_ON_RESET_EN
    while (busy === 1'b1 && busy_cycles < 140000) begin
      busy_cycles++;
      @(negedge clk);
    end
    w = 1'b0;
    mdl.delete();
    if (busy !== 1'b0) begin
      $display("FAIL busy_timeout: got %b expected 0", busy);
      $fatal(1, "clear sequence did not finish");
    end
`endif
  endtask

  // Monitor: on each edge with a live read, pop the expected word; o must match it every cycle.
  always begin
    logic rf, rs;
    @(posedge clk);
    rf = r & ~reset;
    rs = reset;
    #2;
    if (rs || reset) begin
      exp_o = 8'h00;
    end else if (rf) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got read with no expected entry at %0t", $time);
      end else begin
        exp_o = exp_q.pop_front();
      end
    end
    chk("o", {24'h0, o}, {24'h0, exp_o});
`ifndef RAM_DP_CLEAR_ON_RESET_EN
    chk("busy", {31'h0, busy}, 32'h0);
`endif
  end

  initial begin
    int bc;
    reset = 1'b1; w = 1'b0; r = 1'b0; ai = '0; ao = '0; i = '0;
    #1;
    chk("reset_o", {24'h0, o}, 32'h0);
`ifndef RAM_DP_CLEAR_ON_RESET_EN
    chk("reset_busy", {31'h0, busy}, 32'h0);
`endif
    repeat (2) @(negedge clk);
    release_reset(bc);

    // Corner addresses, then read back.
    cyc(1'b1, 17'h00000, 8'hA5, 1'b0, 17'h0);
    cyc(1'b1, 17'h1FFFF, 8'h5A, 1'b0, 17'h0);
    cyc(1'b0, 17'h0, 8'h00, 1'b1, 17'h00000);
    cyc(1'b0, 17'h0, 8'h00, 1'b1, 17'h1FFFF);
    cyc(1'b0, 17'h0, 8'h00, 1'b1, 17'h00000);

    // Mid-cycle reset with r=1: o clears without a clock edge.
    @(negedge clk);
    r = 1'b1; ao = 17'h1FFFF;
    #1 reset = 1'b1;
    #1 chk("async_reset_o", {24'h0, o}, 32'h0);
    repeat (2) @(negedge clk);
    r = 1'b0;
    release_reset(bc);
    cyc(1'b0, 17'h0, 8'h00, 1'b0, 17'h1FFFF);
    cyc(1'b0, 17'h0, 8'h00, 1'b0, 17'h00000);

    // Collision: read-first.
    cyc(1'b1, 17'h00123, 8'h11, 1'b0, 17'h0);
    cyc(1'b1, 17'h00123, 8'h22, 1'b1, 17'h00123);
    cyc(1'b0, 17'h0, 8'h00, 1'b1, 17'h00123);

    // Hold with r=0 while ao moves; w=0 leaves data untouched.
    cyc(1'b0, 17'h0, 8'h00, 1'b0, 17'h1FFFF);
    cyc(1'b0, 17'h00123, 8'hFF, 1'b0, 17'h00000);
    cyc(1'b0, 17'h0, 8'h00, 1'b1, 17'h00123);

    // Reset preservation (with the clear feature the model expects zero).
    cyc(1'b1, 17'h10000, 8'h3C, 1'b0, 17'h0);
    cyc(1'b0, 17'h0, 8'h00, 1'b0, 17'h0);
    @(negedge clk);
    reset = 1'b1;
    release_reset(bc);
    cyc(1'b0, 17'h0, 8'h00, 1'b1, 17'h10000);

    // Random traffic over a small pool so collisions happen often.
    for (int k = 0; k < 16; k++) begin
      pool[k] = 17'($urandom);
      if (k == 0) pool[k] = 17'h00000;
      if (k == 1) pool[k] = 17'h1FFFF;
      cyc(1'b1, pool[k], 8'($urandom), 1'b0, 17'h0);
    end
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom), pool[$urandom_range(15)], 8'($urandom),
          1'($urandom), pool[$urandom_range(15)]);
    end

`ifdef RAM_DP_CLEAR_ON_RESET_EN
    // Busy window length; writes attempted during it must be dropped.
    cyc(1'b1, 17'h10000, 8'h77, 1'b0, 17'h0);
    @(negedge clk);
    reset = 1'b1;
    w = 1'b1; ai = 17'h10000; i = 8'hEE; r = 1'b0;
    @(negedge clk);
    release_reset(bc);
    chk("busy_cycles", bc, 32'd131072);
    cyc(1'b0, 17'h0, 8'h00, 1'b1, 17'h10000);
`endif

    cyc(1'b0, 17'h0, 8'h00, 1'b0, 17'h0);
    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
